// File: rtl/mips_muldiv_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer:
// request opcodes, sequencer states and a small opcode helper.
package mips_muldiv_sequencer_pkg;

    localparam int MULDIV_OP_W = 3;

    typedef logic [MULDIV_OP_W-1:0] muldiv_op_t;

    localparam muldiv_op_t OP_NONE  = 3'd0;
    localparam muldiv_op_t OP_MULT  = 3'd1;
    localparam muldiv_op_t OP_MULTU = 3'd2;
    localparam muldiv_op_t OP_DIV   = 3'd3;
    localparam muldiv_op_t OP_DIVU  = 3'd4;
    localparam muldiv_op_t OP_MTHI  = 3'd5;
    localparam muldiv_op_t OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_FIXUP = 2'd3;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or
// restoring shift-subtract divide (mode=1).
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign rem_sh = {hi, lo[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, opnd};
    // When ge holds the difference is below opnd, so WIDTH bits are exact.
    assign diff   = rem_sh[WIDTH-1:0] - opnd;

    always_comb begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
        if (mode) begin
            hi_nxt = ge ? diff : rem_sh[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/mips_muldiv_sequencer.sv
// Iterative MULT/DIV sequencer owning HI/LO.
// Optional MIPS_MULDIV_EARLY_EXIT_EN: multiply exits once multiplier bits are exhausted.
module mips_muldiv_sequencer
    import mips_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             req_ready,
    input  logic             read_req,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             neg_q;
    logic             neg_r;
    logic             is_div;
    logic             dz_q;

    logic             accept;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign req_ready = (state == ST_IDLE) & ~cancel;
    assign accept    = req_valid & req_ready;
    assign busy      = state != ST_IDLE;
    assign done      = ((state == ST_FIXUP) & ~cancel) | dz_q;
    // FIXUP is the forwarding cycle; the hazard unit takes it from here.
    assign stall     = (req_valid & ~req_ready & (req_op != OP_NONE))
                     | (read_req & busy & ~done);
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign sgn   = is_signed_op(req_op);
    assign a_neg = sgn & req_a[WIDTH-1];
    assign b_neg = sgn & req_b[WIDTH-1];
    assign a_mag = a_neg ? -req_a : req_a;
    assign b_mag = b_neg ? -req_b : req_b;

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fix = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    mips_muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode   (state == ST_DIV),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .opnd   (opnd),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

`ifdef MIPS_MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0]   rem_mask;
    logic               early;
    logic [2*WIDTH-1:0] prod_al;

    assign rem_mask = ~({WIDTH{1'b1}} << cnt);
    assign early    = (acc_lo & rem_mask) == '0;
    assign prod_al  = {acc_hi, acc_lo} >> cnt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            dz_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_MTHI: hi_q <= req_a;
                            OP_MTLO: lo_q <= req_a;
                            OP_MULT, OP_MULTU: begin
                                opnd   <= a_mag;
                                acc_lo <= b_mag;
                                acc_hi <= '0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                                cnt    <= CW'(WIDTH);
                                state  <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (req_b == '0) begin
                                    lo_q <= '1;
                                    hi_q <= req_a;
                                    dz_q <= 1'b1;
                                end else begin
                                    opnd   <= b_mag;
                                    acc_lo <= a_mag;
                                    acc_hi <= '0;
                                    neg_q  <= a_neg ^ b_neg;
                                    neg_r  <= a_neg;
                                    is_div <= 1'b1;
                                    cnt    <= CW'(WIDTH);
                                    state  <= ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end
`ifdef MIPS_MULDIV_EARLY_EXIT_EN
                    else if ((state == ST_MUL) && early) begin
                        {acc_hi, acc_lo} <= prod_al;
                        cnt   <= '0;
                        state <= ST_FIXUP;
                    end
`endif
                    else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    state <= ST_IDLE;
                    if (!cancel) begin
                        if (is_div) begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_sequencer.sv
// Directed vector bench for mips_muldiv_sequencer
// (default build, early exit disabled).
module tb_mips_muldiv_sequencer;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        read_req;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    mips_muldiv_sequencer #(
        .WIDTH(32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .read_req  (read_req),
        .cancel    (cancel),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
        check("req_ready", 64'(req_ready), 64'(1));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
    endtask

    task automatic wait_done(output int lat, output bit seen_busy);
        lat = 0;
        seen_busy = 1'b0;
        while (lat < 40) begin
            @(negedge clock);
            #1;
            lat++;
            if (busy) seen_busy = 1'b1;
            if (done) break;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit seen_busy;
        issue(v.op, v.a, v.b);
        wait_done(lat, seen_busy);
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        if (v.lat == 1)
            check($sformatf("v%0d busy_div0", idx), 64'(seen_busy), 64'(0));
        @(negedge clock);
        #1;
        check($sformatf("v%0d hi", idx), 64'(hi), 64'(v.exp_hi));
        check($sformatf("v%0d lo", idx), 64'(lo), 64'(v.exp_lo));
        check($sformatf("v%0d idle", idx), 64'({busy, done}), 64'(0));
    endtask

    initial begin
        int lat;
        int bad;
        bit seen_busy;
        bit seen_done;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        read_req  = 1'b0;
        cancel    = 1'b0;

        vecs[0]  = '{3'd1, 32'd7, 32'hFFFF_FFFD,
                     32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,
                     32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1};
        vecs[4]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'd0, 32'h8000_0000, 33};
        vecs[6]  = '{3'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 33};
        vecs[7]  = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33};
        vecs[8]  = '{3'd4, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 33};
        vecs[9]  = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 33};
        vecs[10] = '{3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1};
        vecs[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000,
                     32'h4000_0000, 32'd0, 33};

        #12;
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset flags", 64'({busy, done, stall}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // MTHI/MTLO back to back
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_a     = 32'hAAAA;
        #1;
        check("mthi stall", 64'(stall), 64'(0));
        @(negedge clock);
        req_op = 3'd6;
        req_a  = 32'h5555;
        #1;
        check("mtlo stall", 64'(stall), 64'(0));
        check("mthi hi", 64'(hi), 64'(32'hAAAA));
        @(negedge clock);
        req_valid = 1'b0;
        req_op    = 3'd0;
        #1;
        check("mtlo lo", 64'(lo), 64'(32'h5555));
        check("mtlo hi", 64'(hi), 64'(32'hAAAA));

        // read_req hazard and mid-op request
        issue(3'd1, 32'd3, 32'd5);
        read_req = 1'b1;
        bad = 0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clock);
            if (lat == 9) begin
                req_valid = 1'b1;
                req_op    = 3'd2;
                req_a     = 32'd1;
                req_b     = 32'd1;
            end else begin
                req_valid = 1'b0;
                req_op    = 3'd0;
            end
            #1;
            lat++;
            if (lat == 10) begin
                check("midop ready", 64'(req_ready), 64'(0));
                check("midop stall", 64'(stall), 64'(1));
            end
            if (done) break;
            if (stall !== 1'b1) bad++;
        end
        check("hazard stall cycles", 64'(bad), 64'(0));
        check("hazard latency", 64'(lat), 64'(33));
        check("hazard done stall", 64'(stall), 64'(0));
        @(negedge clock);
        read_req = 1'b0;
        #1;
        check("hazard lo", 64'(lo), 64'(15));
        check("hazard hi", 64'(hi), 64'(0));

        // cancel mid-op keeps old HI/LO
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h11, 32'd0);
        issue(3'd1, 32'd7, 32'd9);
        repeat (9) @(negedge clock);
        cancel = 1'b1;
        #1;
        check("cancel ready", 64'(req_ready), 64'(0));
        @(posedge clock);
        #1;
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'(0));
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("cancel no done", 64'(seen_done), 64'(0));
        check("cancel hi", 64'(hi), 64'(32'h11));
        check("cancel lo", 64'(lo), 64'(32'h11));

        // cancel in IDLE rejects the request
        @(negedge clock);
        cancel    = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_a     = 32'h99;
        @(negedge clock);
        cancel    = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        #1;
        check("idle cancel hi", 64'(hi), 64'(32'h11));

        // async reset mid-op
        issue(3'd1, 32'd7, 32'd9);
        repeat (5) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'(0));
        check("async rst hi", 64'(hi), 64'(0));
        check("async rst lo", 64'(lo), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(lat, seen_busy);
        check("post rst no busy", 64'(seen_busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
